// File: rtl/sweep_ctrl.sv
// Frequency sweep controller: sits between the host command decoder and the
// downstream command decoder, forwarding host commands and injecting osc0
// tuning-word commands that step from START to STOP at a tick-based dwell rate.
module sweep_ctrl #(
   parameter int unsigned TUNE_W   = 16,
   parameter logic [7:0]  TUNE_CMD = 8'h01,
   parameter logic [7:0]  CFG_BASE = 8'h40
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              tick,
   input  logic              in_cmd_valid,
   input  logic [7:0]        in_cmd_word,
   input  logic [TUNE_W-1:0] in_data_word,
   output logic              out_cmd_valid,
   output logic [7:0]        out_cmd_word,
   output logic [TUNE_W-1:0] out_data_word,
   output logic              busy,
   output logic              done
);

   typedef enum logic [1:0] {StIdle, StIssue, StDwell, StDone} state_e;

   state_e            state_q;
   logic [TUNE_W-1:0] start_q, stop_q, step_q, dwell_q;
   logic [2:0]        ctrl_q;   // {loop, dir, go}
   logic [TUNE_W-1:0] cur_q;
   logic [TUNE_W-1:0] cnt_q;
   logic              last_q;   // the pending issue is the final one of this pass
   logic              single_q; // degenerate sweep: one issue only, loop ignored

   logic [7:0]        cfg_off;
   logic              is_cfg, fwd, ctrl_wr, go_wr;
   logic [TUNE_W-1:0] dwell_lim, cnt_inc;
   logic [TUNE_W:0]   sum;
   logic              over, deg_go, deg_reload;

   // True when a sweep would consist of START alone.
   function automatic logic is_single(input logic [TUNE_W-1:0] s, input logic [TUNE_W-1:0] p,
                                      input logic [TUNE_W-1:0] st, input logic dn);
      return (st == '0) || (dn ? (s <= p) : (s >= p));
   endfunction

   // Command decode, dwell limit and next-word arithmetic.
   always_comb begin
      cfg_off    = in_cmd_word - CFG_BASE;
      is_cfg     = in_cmd_valid && (in_cmd_word >= CFG_BASE) && (cfg_off < 8'd5);
      fwd        = in_cmd_valid && !is_cfg;
      ctrl_wr    = is_cfg && (cfg_off == 8'd4);
      go_wr      = ctrl_wr && in_data_word[0];
      dwell_lim  = (dwell_q == '0) ? TUNE_W'(1) : dwell_q;
      cnt_inc    = cnt_q + TUNE_W'(1);
      // Extra MSB captures carry (up) or borrow (down).
      sum        = ctrl_q[1] ? ({1'b0, cur_q} - {1'b0, step_q})
                             : ({1'b0, cur_q} + {1'b0, step_q});
      over       = sum[TUNE_W] || (ctrl_q[1] ? (sum[TUNE_W-1:0] <= stop_q)
                                             : (sum[TUNE_W-1:0] >= stop_q));
      deg_go     = is_single(start_q, stop_q, step_q, in_data_word[1]);
      deg_reload = is_single(start_q, stop_q, step_q, ctrl_q[1]);
   end

   // Config registers, output slot arbitration and sweep sequencing.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= StIdle;
         start_q       <= '0;
         stop_q        <= '0;
         step_q        <= '0;
         dwell_q       <= '0;
         ctrl_q        <= '0;
         cur_q         <= '0;
         cnt_q         <= '0;
         last_q        <= 1'b0;
         single_q      <= 1'b0;
         out_cmd_valid <= 1'b0;
         out_cmd_word  <= '0;
         out_data_word <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
      end else begin
         out_cmd_valid <= 1'b0;
         done          <= 1'b0;

         if (is_cfg) begin
            case (cfg_off)
               8'd0:    start_q <= in_data_word;
               8'd1:    stop_q  <= in_data_word;
               8'd2:    step_q  <= in_data_word;
               8'd3:    dwell_q <= in_data_word;
               default: ctrl_q  <= in_data_word[2:0];
            endcase
         end

         // Host traffic owns the slot; a sweep issue waits in StIssue.
         if (fwd) begin
            out_cmd_valid <= 1'b1;
            out_cmd_word  <= in_cmd_word;
            out_data_word <= in_data_word;
         end

         if (go_wr) begin
            state_q  <= StIssue;
            cur_q    <= start_q;
            last_q   <= deg_go;
            single_q <= deg_go;
            cnt_q    <= '0;
            busy     <= 1'b1;
         end else if (ctrl_wr && (state_q != StIdle)) begin
            state_q <= StIdle;
            busy    <= 1'b0;
         end else begin
            case (state_q)
               StIdle: ;
               StIssue: begin
                  if (!fwd) begin
                     out_cmd_valid <= 1'b1;
                     out_cmd_word  <= TUNE_CMD;
                     out_data_word <= cur_q;
                     if (!last_q) begin
                        state_q <= StDwell;
                        cnt_q   <= '0;
                     end else if (ctrl_q[2] && !single_q) begin
                        cur_q    <= start_q;
                        last_q   <= deg_reload;
                        single_q <= deg_reload;
                     end else begin
                        state_q <= StDone;
                     end
                  end
               end
               StDwell: begin
                  if (tick) begin
                     if (cnt_inc >= dwell_lim) begin
                        cur_q   <= over ? stop_q : sum[TUNE_W-1:0];
                        last_q  <= over;
                        cnt_q   <= '0;
                        state_q <= StIssue;
                     end else begin
                        cnt_q <= cnt_inc;
                     end
                  end
               end
               StDone: begin
                  done    <= 1'b1;
                  busy    <= 1'b0;
                  state_q <= StIdle;
               end
               default: state_q <= StIdle;
            endcase
         end
      end
   end

endmodule

// File: doc/sweep_ctrl.md
SWEEP_CTRL -- requirements
Module: sweep_ctrl

Interface
REQ-001: Parameter TUNE_W, default 16, sets the tuning-word and data-word width.
REQ-002: Parameter TUNE_CMD, default 8'h01, is the command code that loads the osc0 tuning word downstream.
REQ-003: Parameter CFG_BASE, default 8'h40, is the base of the sweep configuration command codes CFG_BASE+0 through CFG_BASE+4.
REQ-004: clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-005: rst_n  in  1  synchronous, active-low reset.
REQ-006: tick  in  1  one-cycle sample-rate strobe (divided-clock strobe); the dwell time base.
REQ-007: in_cmd_valid  in  1  one-cycle strobe marking a decoded host SPI command.
REQ-008: in_cmd_word  in  8  host command code.
REQ-009: in_data_word  in  TUNE_W  host data.
REQ-010: out_cmd_valid  out  1  one-cycle strobe to the command decoder.
REQ-011: out_cmd_word  out  8  command code to the command decoder.
REQ-012: out_data_word  out  TUNE_W  data to the command decoder.
REQ-013: busy  out  1  high while a sweep is active.
REQ-014: done  out  1  one-cycle pulse on normal sweep completion.

Function
REQ-015: Configuration registers, all TUNE_W wide: START at CFG_BASE+0, STOP at +1, STEP at +2, DWELL at +3.
REQ-016: CTRL at CFG_BASE+4 SHALL use bit0 = go, bit1 = dir (0 up, 1 down), bit2 = loop.
REQ-017: A host command in the CFG_BASE..CFG_BASE+4 range SHALL update its register on the cycle after in_cmd_valid and SHALL NOT be forwarded.
REQ-018: Any other host command SHALL be forwarded unchanged on out_* with exactly 1 cycle of latency.
REQ-019: States: IDLE, ISSUE, DWELL, DONE.
REQ-020: IDLE -> ISSUE when CTRL is written with go=1; the current word SHALL be set to START; busy SHALL go high on the next cycle.
REQ-021: In ISSUE, the block SHALL emit out_cmd_word = TUNE_CMD and out_data_word = current word for one cycle when the output slot is free, then enter DWELL with the dwell counter cleared.
REQ-022: Arbitration: a forwarded host command has priority over a sweep issue in the same cycle. The sweep issue SHALL be held in ISSUE and emitted on the first cycle with no host command to forward. A sweep issue SHALL never be dropped or duplicated.
REQ-023: In DWELL, the counter SHALL increment on each tick. When the count reaches max(DWELL,1), the next word SHALL be computed and the block SHALL enter ISSUE.
REQ-024: Next-word computation SHALL use TUNE_W+1 bit arithmetic: current + STEP when dir=0, current - STEP when dir=1.
REQ-025: Overshoot is defined as: for dir=0, the result is >= STOP or carries out; for dir=1, the result is <= STOP or borrows.
REQ-026: On overshoot, the current word SHALL be set to STOP and issued, and that issue SHALL be the final one; after it the block SHALL enter DONE.
REQ-027: If loop=1, the block SHALL reload START after the final STOP issue and re-enter ISSUE instead of DONE; done SHALL NOT pulse.
REQ-028: If START is already at or past STOP in the sweep direction, or STEP=0, exactly one issue of START SHALL occur, followed by DONE (loop ignored).
REQ-029: DONE SHALL assert done for 1 cycle, deassert busy, and return to IDLE.
REQ-030: A CTRL write with go=0 in any non-IDLE state SHALL abort to IDLE on the next cycle: busy low, no done, and any held issue discarded.
REQ-031: A CTRL write with go=1 while busy SHALL restart the sweep from the newly latched START.
REQ-032: Configuration writes during a sweep SHALL take effect at the next next-word computation. START SHALL be used only at go or loop reload.
REQ-033: A tick coinciding with the ISSUE state SHALL be ignored.

Reset
REQ-034: While rst_n is low at a clk edge: state = IDLE; out_cmd_valid = 0, out_cmd_word = 0, out_data_word = 0; busy = 0, done = 0.
REQ-035: Reset values for the configuration registers: START = 0, STOP = 0, STEP = 0, DWELL = 0, CTRL = 0; dwell counter = 0.
REQ-036: Reset asserted mid-sweep SHALL discard any pending issue and produce no further output.

Verification
REQ-037: Passthrough: host cmd 0x01, data 0x1234 -> out_cmd_valid exactly 1 cycle later with 0x01 / 0x1234; no configuration register changes.
REQ-038: Up sweep: START=100, STOP=130, STEP=10, DWELL=2, go -> issues 100, 110, 120, 130, each 2 ticks apart, then one done pulse and busy low.
REQ-039: Overshoot, down: START=50, STOP=5, STEP=20, dir=1 -> issues 50, 30, 10, 5, then done.
REQ-040: Collision: host cmd 0x02 valid on the same cycle a sweep issue is due -> 0x02 emitted first; the sweep word emitted on the next free cycle, exactly once.
REQ-041: Abort and loop: loop=1 sweep runs two full passes, then CTRL go=0 is written -> no further issues, busy low, no done pulse.
REQ-042: Reset mid-DWELL -> all outputs 0 the next cycle; a subsequent tick produces no issue.
